pow_arbiter: RTL and testbench
==============================

# pow_arbiter

Shared-resource scheduler for the integer power datapath: accepts `base`/`exp` requests from `NUM_REQ` independent requesters and grants them round-robin to a single iterative square-and-multiply engine. It returns each result tagged with the requester index over a valid/ready response channel. It sits between the stimulus or producer clients and the power unit, so that one multiplier pair serves all clients.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8
- `W`, 32: operand/result width; result is modulo 2^W
- `EXPW`, 5: exponent width; also the engine latency in cycles
- `clk` in 1: clock, rising edge
- `rst` in 1: reset, synchronous, active-high
- `req_valid` in `NUM_REQ`: per-requester request valid
- `req_ready` out `NUM_REQ`: per-requester accept, one-hot or zero
- `req_base` in `NUM_REQ*W`: packed bases, requester i at `[i*W +: W]`
- `req_exp` in `NUM_REQ*EXPW`: packed exponents
- `rsp_valid` out 1: result valid
- `rsp_ready` in 1: consumer accept
- `rsp_data` out W: base^exp mod 2^W
- `rsp_id` out `$clog2(NUM_REQ)`: index of the served requester
- `busy` out 1: high in any state except IDLE
- `rsp_ovf` out 1: true result ≥ 2^W (only with `POW_ARB_OVF_EN`)

## Operation
- FSM: IDLE → CALC → DONE → IDLE.
- IDLE: if any `req_valid`, the winner is the first valid index scanning `ptr, ptr+1, …` modulo `NUM_REQ`. The winner's `req_ready` is driven high combinationally in the same cycle. On that edge:
  - latch base, exp, and id;
  - set `ptr` = winner+1 (wraps);
  - load acc=1, bit counter = EXPW-1;
  - go to CALC.
- IDLE with no `req_valid`: all `req_ready` low. `req_ready` is never high outside IDLE.
- CALC: MSB-first. Each cycle, acc ← acc·acc mod 2^W, then ·base if `exp[bit]`=1. Exactly EXPW cycles regardless of the exp value. After the last bit, go to DONE.
- DONE: `rsp_valid`=1. `rsp_data`/`rsp_id` are stable until `rsp_valid && rsp_ready`, then go to IDLE.
- Special cases: 0^0=1; x^0=1; 0^n=0 for n>0; 1^n=1.
- Requesters hold base/exp stable while valid until accepted. Withdrawing valid before acceptance is allowed and removes that requester from arbitration.
- Reset in any state: go to IDLE, discard the in-flight job, `ptr`=0.
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `busy`=0, `rsp_ovf`=0.

## Timing
- Accepting edge at cycle T: CALC occupies cycles T+1..T+EXPW, and `rsp_valid` is first high in cycle T+EXPW+1.
- A response handshake at edge R returns the FSM to IDLE. The next acceptance is at the earliest edge R+1, so there is one IDLE cycle between jobs. Minimum job period is EXPW+2 cycles.
- `req_ready` is a combinational function of `req_valid`, state and `ptr`. It has no combinational path from `rsp_ready`.
- `rsp_*` outputs are registered.

## Configuration
- `POW_ARB_OVF_EN` defined:
  - `rsp_ovf` port present;
  - a sticky flag clears on acceptance and sets in CALC when any square or multiply product has nonzero bits above W-1;
  - the flag is valid with `rsp_data`.
- Undefined: port absent, no wide-product upper bits kept; `rsp_data` is unchanged.

## Structure
- Package `pow_arb_pkg`:
  - FSM state enum (`IDLE`, `CALC`, `DONE`);
  - `ID_W` localparam helper;
  - the round-robin pick function, which takes a valid vector and `ptr` and returns the index.
- Sub-module `pow_engine`: holds the acc/base/exp/bit-counter registers and the square-and-multiply step. It has `start` and `done` pulses and an optional ovf output. The arbiter owns the FSM, `ptr`, and the response registers.

## Test plan
- Requester 2 only, base=3, exp=5, `rsp_ready`=1: `rsp_data`=243, `rsp_id`=2, `rsp_valid` first high 6 cycles after the accepting edge.
- All 4 requesters valid continuously after reset: acceptance order is 0,1,2,3,0. Each job period is 7 cycles.
- Edge values, one request each:
  - base=0, exp=0 → 1;
  - base=5, exp=0 → 1;
  - base=0, exp=7 → 0;
  - base=2, exp=31 → 0x8000_0000;
  - base=2, exp=32 is not representable; instead use base=4, exp=16 → 0, with `rsp_ovf`=1 when `POW_ARB_OVF_EN` is defined.
- `rsp_ready` low for 3 cycles in DONE: `rsp_valid`, `rsp_data` and `rsp_id` are held. No `req_ready` is asserted until one cycle after the handshake.
- `rst` asserted in the 3rd CALC cycle: next cycle all outputs are 0 and `busy`=0. With requesters 1 and 3 valid, the next grant goes to 1 (`ptr`=0).

Source files
------------

// File: rtl/pow_arb_pkg.sv
// Shared types and helpers for the round-robin power arbiter.
// The optional overflow flag is enabled by defining POW_ARB_OVF_EN.
package pow_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int MAX_REQ = 8;

    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // First valid index found when scanning ptr, ptr+1, ... modulo num_req.
    function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                           input logic [2:0] ptr,
                                           input int num_req);
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = (int'(ptr) + i) % num_req;
            if (!found && (i < num_req) && valid[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/pow_engine.sv
// Iterative MSB-first square-and-multiply engine, one exponent bit per cycle.
// With POW_ARB_OVF_EN defined it also reports a sticky overflow flag.
module pow_engine #(
    parameter int W    = 32,
    parameter int EXPW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [W-1:0]    base,
    input  logic [EXPW-1:0] exp,
    output logic            done,
    output logic [W-1:0]    result
`ifdef POW_ARB_OVF_EN
    ,
    output logic            ovf
`endif
);

    localparam int CNT_W = (EXPW > 1) ? $clog2(EXPW) : 1;

    logic [W-1:0]     acc;
    logic [W-1:0]     base_r;
    logic [EXPW-1:0]  exp_r;
    logic [CNT_W-1:0] bit_cnt;
    logic             running;
    logic [W-1:0]     step;

`ifdef POW_ARB_OVF_EN
    logic [2*W-1:0] sq_full;
    logic [2*W-1:0] mul_full;
    logic           step_ovf;
    logic           ovf_r;

    // Full-width products so bits lost to the modulo can be flagged.
    always_comb begin
        sq_full  = (2*W)'(acc) * (2*W)'(acc);
        mul_full = exp_r[bit_cnt] ? (2*W)'(sq_full[W-1:0]) * (2*W)'(base_r)
                                  : (2*W)'(sq_full[W-1:0]);
        step     = mul_full[W-1:0];
        step_ovf = (|sq_full[2*W-1:W]) | (exp_r[bit_cnt] & (|mul_full[2*W-1:W]));
    end

    assign ovf = ovf_r | step_ovf;
`else
    logic [W-1:0] sq;

    always_comb begin
        sq   = acc * acc;
        step = exp_r[bit_cnt] ? sq * base_r : sq;
    end
`endif

    assign done   = running && (bit_cnt == '0);
    assign result = step;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            base_r  <= '0;
            exp_r   <= '0;
            bit_cnt <= '0;
            running <= 1'b0;
`ifdef POW_ARB_OVF_EN
            ovf_r   <= 1'b0;
`endif
        end else if (start) begin
            acc     <= W'(1);
            base_r  <= base;
            exp_r   <= exp;
            bit_cnt <= CNT_W'(EXPW - 1);
            running <= 1'b1;
`ifdef POW_ARB_OVF_EN
            ovf_r   <= 1'b0;
`endif
        end else if (running) begin
            acc     <= step;
            bit_cnt <= bit_cnt - 1'b1;
            if (done) begin
                running <= 1'b0;
            end
`ifdef POW_ARB_OVF_EN
            ovf_r   <= ovf_r | step_ovf;
`endif
        end
    end

endmodule

// File: rtl/pow_arbiter.sv
// Round-robin arbiter sharing one pow_engine among NUM_REQ requesters.
// Define POW_ARB_OVF_EN to add the rsp_ovf output.
module pow_arbiter
    import pow_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int W       = 32,
    parameter int EXPW    = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*W-1:0]       req_base,
    input  logic [NUM_REQ*EXPW-1:0]    req_exp,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [W-1:0]               rsp_data,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic                       busy
`ifdef POW_ARB_OVF_EN
    ,
    output logic                       rsp_ovf
`endif
);

    localparam int ID_W = id_width(NUM_REQ);

    state_t          state;
    state_t          state_next;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] cur_id;
    logic            start;
    logic [W-1:0]    sel_base;
    logic [EXPW-1:0] sel_exp;
    logic            eng_done;
    logic [W-1:0]    eng_result;
`ifdef POW_ARB_OVF_EN
    logic            eng_ovf;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|req_valid) state_next = CALC;
            CALC:    if (eng_done) state_next = DONE;
            DONE:    if (rsp_valid && rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Grant is purely a function of req_valid, state and ptr; rsp_ready never feeds it.
    always_comb begin
        winner    = ID_W'(rr_pick(MAX_REQ'(req_valid), 3'(ptr), NUM_REQ));
        start     = (state == IDLE) && (|req_valid);
        busy      = (state != IDLE);
        req_ready = '0;
        if (start) begin
            req_ready[winner] = 1'b1;
        end
        sel_base = req_base[int'(winner)*W +: W];
        sel_exp  = req_exp[int'(winner)*EXPW +: EXPW];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            cur_id    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
`ifdef POW_ARB_OVF_EN
            rsp_ovf   <= 1'b0;
`endif
        end else begin
            if (start) begin
                cur_id <= winner;
                ptr    <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
            end
            if (eng_done) begin
                rsp_valid <= 1'b1;
                rsp_data  <= eng_result;
                rsp_id    <= cur_id;
`ifdef POW_ARB_OVF_EN
                rsp_ovf   <= eng_ovf;
`endif
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    pow_engine #(
        .W    (W),
        .EXPW (EXPW)
    ) u_engine (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .base   (sel_base),
        .exp    (sel_exp),
        .done   (eng_done),
        .result (eng_result)
`ifdef POW_ARB_OVF_EN
        ,
        .ovf    (eng_ovf)
`endif
    );

endmodule

// File: tb/tb_pow_arbiter.sv
// Self-checking bench for pow_arbiter: a cycle-level reference model plus directed scenarios.
// Covers the POW_ARB_OVF_EN build as well when that macro is defined.
module tb_pow_arbiter;

    localparam int NUM_REQ = 4;
    localparam int W       = 32;
    localparam int EXPW    = 5;

    logic                    clk;
    logic                    rst;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*W-1:0]    req_base;
    logic [NUM_REQ*EXPW-1:0] req_exp;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [W-1:0]            rsp_data;
    logic [1:0]              rsp_id;
    logic                    busy;
    logic                    rsp_ovf;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model state: phase 0 idle, 1 computing, 2 holding a response.
    int          m_phase = 0;
    int          m_ptr = 0;
    int          m_cnt = 0;
    int          m_id = 0;
    int          m_id_pend = 0;
    logic [31:0] m_data = '0;
    logic [31:0] m_pend = '0;
    logic        m_ovf = 1'b0;
    logic        m_ovf_pend = 1'b0;
    bit          m_known = 1'b0;
    int          acc_id[$];
    int          acc_cyc[$];
    int          hs_cyc[$];

    pow_arbiter #(
        .NUM_REQ (NUM_REQ),
        .W       (W),
        .EXPW    (EXPW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_base  (req_base),
        .req_exp   (req_exp),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
`ifdef POW_ARB_OVF_EN
        ,
        .rsp_ovf   (rsp_ovf)
`endif
    );

`ifndef POW_ARB_OVF_EN
    assign rsp_ovf = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Plain repeated multiplication; overflow tracked on the exact product.
    function automatic logic [32:0] model_pow(input logic [31:0] b, input logic [4:0] e);
        logic [31:0] r;
        logic [63:0] full;
        logic        ovf;
        r    = 32'd1;
        full = 64'd1;
        ovf  = 1'b0;
        for (int k = 0; k < int'(e); k++) begin
            r = r * b;
            if (!ovf) begin
                full = full * {32'd0, b};
                if (full[63:32] != 32'd0) ovf = 1'b1;
            end
        end
        return {ovf, r};
    endfunction

    function automatic int rr_model(input logic [NUM_REQ-1:0] v, input int p);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        end
        return 0;
    endfunction

    // Compare DUT against the model every cycle, then advance the model for the coming edge.
    always @(negedge clk) begin
        logic [NUM_REQ-1:0] want_ready;
        logic [32:0]        pr;
        int                 w;
        if (m_known) begin
            want_ready = '0;
            if (m_phase == 0 && (|req_valid)) want_ready[rr_model(req_valid, m_ptr)] = 1'b1;
            check_output("cyc req_ready", 64'(req_ready), 64'(want_ready));
            check_output("cyc busy", 64'(busy), 64'(m_phase != 0));
            check_output("cyc rsp_valid", 64'(rsp_valid), 64'(m_phase == 2));
            check_output("cyc rsp_data", 64'(rsp_data), 64'(m_data));
            check_output("cyc rsp_id", 64'(rsp_id), 64'(m_id));
`ifdef POW_ARB_OVF_EN
            check_output("cyc rsp_ovf", 64'(rsp_ovf), 64'(m_ovf));
`endif
        end
        if (rst) begin
            m_phase = 0;
            m_ptr   = 0;
            m_data  = '0;
            m_id    = 0;
            m_ovf   = 1'b0;
            m_known = 1'b1;
        end else if (m_known) begin
            case (m_phase)
                0: if (|req_valid) begin
                    w  = rr_model(req_valid, m_ptr);
                    pr = model_pow(req_base[w*W +: W], req_exp[w*EXPW +: EXPW]);
                    acc_id.push_back(w);
                    acc_cyc.push_back(cyc);
                    m_pend     = pr[31:0];
                    m_ovf_pend = pr[32];
                    m_id_pend  = w;
                    m_ptr      = (w + 1) % NUM_REQ;
                    m_cnt      = EXPW;
                    m_phase    = 1;
                end
                1: begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_phase = 2;
                        m_data  = m_pend;
                        m_id    = m_id_pend;
                        m_ovf   = m_ovf_pend;
                    end
                end
                default: if (rsp_ready) begin
                    m_phase = 0;
                    hs_cyc.push_back(cyc);
                end
            endcase
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst       = 1'b1;
        req_valid = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic apply_stimulus(input int idx, input logic [31:0] b, input logic [4:0] e);
        req_base[idx*W +: W]       = b;
        req_exp[idx*EXPW +: EXPW]  = e;
        req_valid[idx]             = 1'b1;
    endtask

    task automatic wait_accept(input int idx, input string tag, output int t_acc);
        bit seen = 1'b0;
        t_acc = 0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            if (req_ready[idx]) begin
                seen  = 1'b1;
                t_acc = cyc;
            end
        end
        if (!seen) check_output({tag, " accept timeout"}, 64'd0, 64'd1);
    endtask

    task automatic wait_idle(input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (!busy && !rsp_valid) seen = 1'b1;
        end
        if (!seen) check_output({tag, " idle timeout"}, 64'd0, 64'd1);
    endtask

    // One isolated request with rsp_ready high; pins result, id and latency to literals.
    task automatic single_job(input int idx, input logic [31:0] b, input logic [4:0] e,
                              input logic [31:0] want, input logic want_ovf, input string tag);
        int t_acc;
        bit seen;
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        apply_stimulus(idx, b, e);
        wait_accept(idx, tag, t_acc);
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1'b1;
                check_output({tag, " latency"}, 64'(cyc - t_acc), 64'(EXPW + 1));
                check_output({tag, " data"}, 64'(rsp_data), 64'(want));
                check_output({tag, " id"}, 64'(rsp_id), 64'(idx));
`ifdef POW_ARB_OVF_EN
                check_output({tag, " ovf"}, 64'(rsp_ovf), 64'(want_ovf));
`endif
            end
        end
        if (!seen) check_output({tag, " rsp timeout"}, 64'd0, 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        int t_acc;
        int n0;
        int d_cyc;
        int exp_order[5] = '{0, 1, 2, 3, 0};
        rst       = 1'b1;
        req_valid = '0;
        req_base  = '0;
        req_exp   = '0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_output("reset rsp_valid", 64'(rsp_valid), 64'd0);
        check_output("reset rsp_data", 64'(rsp_data), 64'd0);
        check_output("reset busy", 64'(busy), 64'd0);
        check_output("reset req_ready", 64'(req_ready), 64'd0);

        single_job(2, 32'd3, 5'd5, 32'd243, 1'b0, "pow 3^5");
        single_job(0, 32'd0, 5'd0, 32'd1, 1'b0, "pow 0^0");
        single_job(1, 32'd5, 5'd0, 32'd1, 1'b0, "pow 5^0");
        single_job(3, 32'd0, 5'd7, 32'd0, 1'b0, "pow 0^7");
        single_job(2, 32'd2, 5'd31, 32'h8000_0000, 1'b0, "pow 2^31");
        single_job(0, 32'd4, 5'd16, 32'd0, 1'b1, "pow 4^16");
        single_job(1, 32'd1, 5'd31, 32'd1, 1'b0, "pow 1^31");
        single_job(3, 32'd7, 5'd11, 32'd1977326743, 1'b0, "pow 7^11");

        // All four requesters valid from reset: strict rotation with a 7-cycle period.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) apply_stimulus(i, 32'(i + 2), 5'd3);
        n0 = acc_id.size();
        for (int k = 0; k < 80 && acc_id.size() < n0 + 5; k++) begin
            @(negedge clk); #1;
        end
        if (acc_id.size() < n0 + 5) begin
            check_output("rr accept timeout", 64'd0, 64'd1);
        end else begin
            for (int j = 0; j < 5; j++) check_output("rr order", 64'(acc_id[n0 + j]), 64'(exp_order[j]));
            for (int j = 1; j < 5; j++) check_output("rr period", 64'(acc_cyc[n0 + j] - acc_cyc[n0 + j - 1]), 64'd7);
        end
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle("rr");

        // Consumer stalls for three DONE cycles while another requester waits.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        apply_stimulus(0, 32'd3, 5'd4);
        wait_accept(0, "hold", t_acc);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        apply_stimulus(1, 32'd7, 5'd2);
        d_cyc = -1;
        for (int k = 0; k < 30 && d_cyc < 0; k++) begin
            @(negedge clk);
            if (rsp_valid) d_cyc = cyc;
        end
        if (d_cyc < 0) check_output("hold rsp timeout", 64'd0, 64'd1);
        for (int j = 0; j < 3; j++) begin
            if (j > 0) @(negedge clk);
            check_output("hold rsp_valid", 64'(rsp_valid), 64'd1);
            check_output("hold rsp_data", 64'(rsp_data), 64'd81);
            check_output("hold rsp_id", 64'(rsp_id), 64'd0);
            check_output("hold req_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check_output("hold req_ready at handshake", 64'(req_ready), 64'd0);
        @(negedge clk); #1;
        check_output("post-hold req_ready", 64'(req_ready), 64'b0010);
        check_output("post-hold gap", 64'(cyc - hs_cyc[$]), 64'd1);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        wait_idle("hold");
        check_output("hold second data", 64'(rsp_data), 64'd49);

        // Reset in the 3rd compute cycle discards the job and rewinds the pointer.
        @(posedge clk); #1;
        apply_stimulus(2, 32'd3, 5'd5);
        wait_accept(2, "rstcalc", t_acc);
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_output("rstcalc busy", 64'(busy), 64'd0);
        check_output("rstcalc rsp_valid", 64'(rsp_valid), 64'd0);
        check_output("rstcalc rsp_data", 64'(rsp_data), 64'd0);
        check_output("rstcalc rsp_id", 64'(rsp_id), 64'd0);
        check_output("rstcalc req_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        apply_stimulus(1, 32'd6, 5'd2);
        apply_stimulus(3, 32'd9, 5'd2);
        @(negedge clk);
        check_output("rstcalc grant", 64'(req_ready), 64'b0010);
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle("rstcalc");
        check_output("rstcalc job id", 64'(rsp_id), 64'd1);
        check_output("rstcalc job data", 64'(rsp_data), 64'd36);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
